rot_position_gen: RTL and testbench
===================================

# rot_position_gen

Sequencer driving the 4-bit position code (0–11) into the four-display rotating-segment decoder. It advances a single lit segment around the perimeter of the four 7-segment displays at a programmable rate, in either direction. It supports free-run and single-step from a pushbutton. It sits between the board switches/keys and the rotation decoder and is the only producer of the decoder's position input.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `STEP_HZ`, default 8: base step rate at `speed`=0. `DIV = CLK_HZ/STEP_HZ` must be ≥2.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `run`, in, 1: level. 1 = free-run, 0 = stopped.
- `dir`, in, 1: 0 = forward (increment), 1 = reverse (decrement).
- `speed`, in, 2: step period = `DIV << speed` clocks, so rates are ×1, ×½, ×¼ and ×⅛ of `STEP_HZ`.
- `step_n`, in, 1: raw pushbutton, active-low and asynchronous. Single-step when stopped.
- `pos_out`, out, 4: position code 0–11 to the decoder. Registered.
- `step_pulse`, out, 1: one-cycle pulse in the cycle `pos_out` takes a new value.
- `lap_done`, out, 1: one-cycle pulse when a step wraps. Forward wrap is 11→0; reverse wrap is 0→11.

## Operation
- Position map:
  - 0–3: segment a of displays 0→3.
  - 4–5: segments b, c of display 3.
  - 6–9: segment d of displays 3→0.
  - 10–11: segments e, f of display 0.
- Codes 12–15 are never produced.
- FSM has two states:
  - STOP. Reset state.
  - RUN.
- STOP→RUN when synchronized `run`=1. RUN→STOP when `run`=0. The transition takes effect on the next edge.
- Prescaler:
  - Counts only in RUN. Cleared to 0 in STOP and on entry to RUN.
  - `tick` = (count ≥ (DIV<<speed)−1). On tick the count returns to 0.
  - Using ≥ means a speed change mid-count never overruns. After a shortened limit, the next cycle ticks.
- Step event = `tick` in RUN, or a falling edge of synchronized `step_n` in STOP. `step_n` edges in RUN are ignored and not queued.
- On a step event:
  - Forward: `pos_out` ← (pos==11) ? 0 : pos+1.
  - Reverse: `pos_out` ← (pos==0) ? 11 : pos−1.
  - `dir` is sampled on the step-event cycle only.
- `run`, `dir` and `speed` are assumed quasi-static switches. `run` passes through a 2-flop synchronizer. `step_n` passes through a 2-flop synchronizer plus a falling-edge detector.
- No debounce. Upstream key hardware or the bench guarantees clean edges.
- Reset, including mid-run: `pos_out`=0, `step_pulse`=0, `lap_done`=0, prescaler 0, state STOP, synchronizer flops 1 for `step_n` and 0 for `run`.
- Reset release with `step_n` held low must not produce a step.

## Timing
- Step latency: `pos_out`, `step_pulse` and `lap_done` update on the clock edge after the step-event cycle.
- In RUN with constant `speed`, consecutive `step_pulse`s are exactly `DIV<<speed` clocks apart.
- First step after `run` rises lands `2 + 1 + (DIV<<speed)` clocks after `run` is sampled high. The breakdown is:
  - 2: synchronizer.
  - 1: FSM.
  - `DIV<<speed`: full period.
- `step_n` falling edge to `pos_out` change: 4 clocks (2 sync + 1 edge detect + 1 update).
- `lap_done` is asserted only together with `step_pulse`.
- `run` falling mid-period: no further step, `pos_out` holds, prescaler clears. Re-entering RUN always waits a full period.

## Structure
- Package `rot_pkg` holds:
  - `NUM_POS`=12 and `LAST_POS`=11.
  - Named position constants: `POS_TOP0`=0, `POS_RIGHT_B`=4, `POS_BOT3`=6, `POS_LEFT_E`=10.
  - Speed encoding constants.
  - FSM state enum {STOP, RUN}.
- Sub-module `sync_edge_n`: 2-flop synchronizer with reset value 1, plus registered falling-edge pulse. Instantiated for `step_n`.
- Prescaler width is `$clog2(DIV*8)`.

## Test plan
All cases use `CLK_HZ`=16 and `STEP_HZ`=4, so DIV=4.
- Reset → `pos_out`=0, no pulses. Then `run`=1, `dir`=0, `speed`=0 → `pos_out` steps 1,2,…,11,0 with pulses exactly 4 clocks apart, and `lap_done` only on 11→0.
- `dir`=1 from `pos_out`=0 → 11,10,…; `lap_done` on 0→11. Flip `dir` mid-run → reverses at the next step with no skipped code.
- `speed`=3 → pulses 32 clocks apart. Switch to `speed`=0 when count=20 → step on the next cycle, then every 4 clocks.
- `run`=0 at `pos_out`=5 → holds 5. Three `step_n` low pulses → 6,7,8, each 4 clocks after its falling edge. `step_n` pulses while `run`=1 → no extra steps.
- Assert `reset_n` low mid-run at `pos_out`=9 → all outputs 0 immediately (asynchronous). Release with `step_n` held low → no step; state STOP.

Source files
------------

// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared constants, state type and position helpers for the rotating-segment sequencer
package rot_pkg;

    localparam int         NUM_POS     = 12;
    localparam logic [3:0] LAST_POS    = 4'd11;

    localparam logic [3:0] POS_TOP0    = 4'd0;
    localparam logic [3:0] POS_RIGHT_B = 4'd4;
    localparam logic [3:0] POS_BOT3    = 4'd6;
    localparam logic [3:0] POS_LEFT_E  = 4'd10;

    localparam logic [1:0] SPEED_X1      = 2'd0;
    localparam logic [1:0] SPEED_HALF    = 2'd1;
    localparam logic [1:0] SPEED_QUARTER = 2'd2;
    localparam logic [1:0] SPEED_EIGHTH  = 2'd3;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] next_pos(input logic [3:0] pos, input logic rev);
        if (rev) begin
            next_pos = (pos == POS_TOP0) ? LAST_POS : pos - 4'd1;
        end else begin
            next_pos = (pos == LAST_POS) ? POS_TOP0 : pos + 4'd1;
        end
    endfunction

    function automatic logic is_wrap(input logic [3:0] pos, input logic rev);
        is_wrap = rev ? (pos == POS_TOP0) : (pos == LAST_POS);
    endfunction

endpackage

// File: rtl/sync_edge_n.sv
// rtl/sync_edge_n.sv - 2-flop synchronizer (idle high) with registered falling-edge pulse
module sync_edge_n (
    input  logic clk,
    input  logic reset_n,
    input  logic din_n_i,
    output logic fall_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic       fall_q;
    logic [2:0] vld_q;

    // vld_q marks when prev_q holds a real sample, so an input already low at
    // reset release is not mistaken for a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            vld_q  <= 3'b000;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din_n_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            vld_q  <= {vld_q[1:0], 1'b1};
            fall_q <= vld_q[2] & prev_q & ~s2_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/rot_position_gen.sv
// rtl/rot_position_gen.sv - position sequencer (0-11) with prescaled free-run and single-step
module rot_position_gen
    import rot_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       dir,
    input  logic [1:0] speed,
    input  logic       step_n,
    output logic [3:0] pos_out,
    output logic       step_pulse,
    output logic       lap_done
);

    localparam int          DIV   = CLK_HZ / STEP_HZ;
    localparam int          CW    = $clog2(DIV * 8);
    localparam logic [CW:0] DIV_W = (CW + 1)'(DIV);
    localparam logic [CW:0] ONE_W = (CW + 1)'(1);

    logic          run_s1_q;
    logic          run_s2_q;
    logic          step_fall;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    pos_q;
    logic          step_pulse_q;
    logic          lap_q;

    logic [CW:0]   period;
    logic          tick;
    logic          step_ev;
    logic [3:0]    pos_d;

    sync_edge_n u_step_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din_n_i (step_n),
        .fall_o  (step_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            run_s1_q <= run;
            run_s2_q <= run_s1_q;
        end
    end

    // Compare with >= so a speed change that shortens the limit ticks at once.
    always_comb begin
        period  = DIV_W << speed;
        tick    = (state_q == RUN) && ({1'b0, cnt_q} >= (period - ONE_W));
        step_ev = tick || ((state_q == STOP) && step_fall);
        pos_d   = step_ev ? next_pos(pos_q, dir) : pos_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= STOP;
            cnt_q        <= '0;
            pos_q        <= POS_TOP0;
            step_pulse_q <= 1'b0;
            lap_q        <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            step_pulse_q <= step_ev;
            lap_q        <= step_ev && is_wrap(pos_q, dir);
            case (state_q)
                STOP: begin
                    cnt_q <= '0;
                    if (run_s2_q) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!run_s2_q) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= STOP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pos_out    = pos_q;
    assign step_pulse = step_pulse_q;
    assign lap_done   = lap_q;

endmodule

// File: tb/tb_rot_position_gen.sv
// tb/tb_rot_position_gen.sv - randomized and directed bench for rot_position_gen against a sample-history model
module tb_rot_position_gen;
    import rot_pkg::*;

    localparam int CLK_HZ  = 16;
    localparam int STEP_HZ = 4;
    localparam int DIV     = CLK_HZ / STEP_HZ;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       run     = 1'b0;
    logic       dir     = 1'b0;
    logic [1:0] speed   = SPEED_X1;
    logic       step_n  = 1'b1;
    logic [3:0] pos_out;
    logic       step_pulse;
    logic       lap_done;

    rot_position_gen #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .dir        (dir),
        .speed      (speed),
        .step_n     (step_n),
        .pos_out    (pos_out),
        .step_pulse (step_pulse),
        .lap_done   (lap_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: input samples per clock edge since reset release; outputs follow
    // from the sync delays, the step period and the position ring rules.
    bit rs_h [0:31999];
    bit ss_h [0:31999];
    int m_edge = 0;
    bit m_run  = 0;
    int m_cnt  = 0;
    int m_pos  = 0;

    always @(posedge clk) begin : model
        int per;
        bit ev;
        bit wrap;
        bit run_sync;
        if (!reset_n) begin
            m_edge = 0;
            m_run  = 0;
            m_cnt  = 0;
            m_pos  = 0;
        end else begin
            m_edge++;
            rs_h[m_edge] = run;
            ss_h[m_edge] = step_n;
            per = DIV << speed;
            if (m_run) ev = (m_cnt >= per - 1);
            else       ev = (m_edge >= 5) && ss_h[m_edge-4] && !ss_h[m_edge-3];
            run_sync = (m_edge >= 3) && rs_h[m_edge-2];
            wrap = 0;
            if (ev) begin
                if (!dir) begin
                    wrap  = (m_pos == NUM_POS - 1);
                    m_pos = (m_pos + 1) % NUM_POS;
                end else begin
                    wrap  = (m_pos == 0);
                    m_pos = (m_pos + NUM_POS - 1) % NUM_POS;
                end
            end
            if (m_run && run_sync && !ev) m_cnt++;
            else                          m_cnt = 0;
            m_run = run_sync;
            #1;
            check("model_pos_out", 32'(pos_out), 32'(m_pos));
            check("model_step_pulse", 32'(step_pulse), 32'(ev));
            check("model_lap_done", 32'(lap_done), 32'(ev && wrap));
        end
    end

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!step_pulse && n < limit);
        if (!step_pulse) n = -1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int k;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pos", 32'(pos_out), 0);
        check("reset_pulse", 32'(step_pulse), 0);
        check("reset_lap", 32'(lap_done), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        run = 1'b1;
        wait_pulse(40, n);
        check("first_step_latency", n, 7);
        check("first_pos", 32'(pos_out), 1);
        for (int i = 0; i < 11; i++) begin
            wait_pulse(10, n);
            check("fwd_interval", n, 4);
        end
        check("fwd_wrap_pos", 32'(pos_out), 0);
        check("fwd_wrap_lap", 32'(lap_done), 1);

        @(negedge clk);
        dir = 1'b1;
        wait_pulse(10, n);
        check("rev_wrap_pos", 32'(pos_out), 11);
        check("rev_wrap_lap", 32'(lap_done), 1);
        for (int i = 0; i < 5; i++) wait_pulse(10, n);
        check("rev_pos6", 32'(pos_out), 6);
        @(negedge clk);
        @(negedge clk);
        dir = 1'b0;
        wait_pulse(10, n);
        check("dir_flip_pos", 32'(pos_out), 7);

        @(negedge clk);
        speed = SPEED_EIGHTH;
        wait_pulse(60, n);
        check("speed3_interval", n, 32);
        repeat (21) @(negedge clk);
        speed = SPEED_X1;
        wait_pulse(10, n);
        check("speed_shrink_latency", n, 1);
        check("speed_shrink_pos", 32'(pos_out), 9);
        wait_pulse(10, n);
        check("speed0_after_shrink", n, 4);

        k = 0;
        while (pos_out != 4'd5 && k < 20) begin
            wait_pulse(10, n);
            k++;
        end
        @(negedge clk);
        run = 1'b0;
        repeat (12) @(negedge clk);
        check("stop_hold_pos", 32'(pos_out), 5);

        for (int i = 0; i < 3; i++) begin
            step_n = 1'b0;
            wait_pulse(10, n);
            check("step_n_latency", n, 4);
            check("step_n_pos", 32'(pos_out), 6 + i);
            repeat (4) @(negedge clk);
            step_n = 1'b1;
            repeat (6) @(negedge clk);
        end

        speed = SPEED_HALF;
        run   = 1'b1;
        wait_pulse(40, n);
        check("speed1_first_latency", n, 11);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            step_n = 1'b0;
            wait_pulse(20, n);
            check("run_ignores_step_n", n, 8);
            @(negedge clk);
            step_n = 1'b1;
            wait_pulse(20, n);
            check("run_ignores_step_n", n, 8);
        end

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_n = ~step_n;
        end

        @(negedge clk);
        run    = 1'b1;
        dir    = 1'b0;
        speed  = SPEED_X1;
        step_n = 1'b1;
        k = 0;
        do begin
            wait_pulse(40, n);
            k++;
        end while (pos_out != 4'd9 && k < 40);
        check("reach_pos9", 32'(pos_out), 9);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        run     = 1'b0;
        step_n  = 1'b0;
        #1;
        check("async_reset_pos", 32'(pos_out), 0);
        check("async_reset_pulse", 32'(step_pulse), 0);
        check("async_reset_lap", 32'(lap_done), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("release_low_no_step", 32'(pos_out), 0);
        step_n = 1'b1;
        repeat (4) @(negedge clk);
        step_n = 1'b0;
        wait_pulse(10, n);
        check("post_reset_step_latency", n, 4);
        check("post_reset_step_pos", 32'(pos_out), 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
